// File: rtl/crop_seq_pkg.sv
// Shared constants, state encoding and window decode for the crop/Gauss frame sequencer.
package crop_seq_pkg;

  localparam int FP_TOTAL = 16;
  localparam int IN_ROWS  = 100;
  localparam int IN_COLS  = 160;
  localparam int OUT_ROWS = 48;
  localparam int OUT_COLS = 48;
  localparam int Y_1      = 10;
  localparam int X_1      = 10;
  localparam int NUM_OUT  = 5;

  localparam int ROW_W = $clog2(IN_ROWS);
  localparam int COL_W = $clog2(IN_COLS);
  localparam int CNT_W = $clog2(OUT_ROWS * OUT_COLS + 1);

  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(Y_1);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(Y_1 + OUT_ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(X_1);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(X_1 + OUT_COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_COLS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  function automatic logic in_window(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
  endfunction

  // Network output lanes are only accepted while a frame is in flight.
  function automatic logic is_collect(input state_t st);
    return (st == START) || (st == STREAM) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/crop_frame_sequencer_filter.sv
// Raster position tracking and crop-window selection with a one-entry output buffer
// that sustains one pixel per cycle when it drains and refills together.
module crop_window_filter
  import crop_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [FP_TOTAL-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [FP_TOTAL-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                buf_empty,
  output logic                frame_end
);

  logic [ROW_W-1:0]    row_r;
  logic [COL_W-1:0]    col_r;
  logic                buf_full_r;
  logic [FP_TOTAL-1:0] buf_data_r;
  logic [CNT_W-1:0]    fwd_r;

  logic inside_s;
  logic ready_s;
  logic accept_s;
  logic fill_s;
  logic drain_s;
  logic col_end_s;
  logic row_end_s;
  logic last_s;

  // Acceptance decode against the current raster position.
  always_comb begin
    inside_s  = in_window(row_r, col_r);
    col_end_s = (col_r == COL_LAST);
    row_end_s = (row_r == ROW_LAST);
    if (!en) begin
      ready_s = 1'b0;
    end else if (!inside_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = !buf_full_r || m_tready;
    end
    accept_s = s_tvalid && ready_s;
    fill_s   = accept_s && inside_s;
    drain_s  = buf_full_r && m_tready;
    last_s   = accept_s && col_end_s && row_end_s;
  end

  assign s_tready  = ready_s;
  assign m_tvalid  = buf_full_r;
  assign m_tdata   = buf_data_r;
  assign buf_empty = !buf_full_r;
  assign frame_end = last_s;

  // Raster counters; both wrap on the last pixel so the next frame starts at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= '0;
      col_r <= '0;
    end else if (accept_s) begin
      if (col_end_s) begin
        col_r <= '0;
        row_r <= row_end_s ? '0 : row_r + 1'b1;
      end else begin
        col_r <= col_r + 1'b1;
      end
    end
  end

  // Output buffer; data only loads on a fill, so it holds steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_r <= 1'b0;
      buf_data_r <= '0;
      fwd_r      <= '0;
    end else begin
      if (fill_s) begin
        buf_full_r <= 1'b1;
        buf_data_r <= s_tdata;
      end else if (drain_s) begin
        buf_full_r <= 1'b0;
      end
      if (last_s) begin
        fwd_r <= '0;
      end else if (fill_s) begin
        fwd_r <= fwd_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/crop_frame_sequencer.sv
// Per-frame sequencer: starts the network, streams the crop window into it and
// gathers one beat per network output lane into a single result word.
module crop_frame_sequencer
  import crop_seq_pkg::*;
(
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        cmd_start,
  output logic                        busy,
  input  logic [FP_TOTAL-1:0]         s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [FP_TOTAL-1:0]         m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        net_ap_start,
  input  logic                        net_ap_ready,
  input  logic                        net_ap_done,
  input  logic [NUM_OUT*FP_TOTAL-1:0] res_tdata,
  input  logic [NUM_OUT-1:0]          res_tvalid,
  output logic [NUM_OUT-1:0]          res_tready,
  output logic [NUM_OUT*FP_TOTAL-1:0] result_data,
  output logic                        result_valid,
  input  logic                        result_ready
);

  state_t state_r;
  state_t next_s;

  logic [NUM_OUT-1:0]          got_r;
  logic [NUM_OUT-1:0]          got_next_s;
  logic [NUM_OUT-1:0]          take_s;
  logic [NUM_OUT-1:0]          res_ready_r;
  logic                        done_seen_r;
  logic                        collect_s;
  logic                        release_s;
  logic                        stream_en_s;
  logic                        buf_empty_s;
  logic                        frame_end_s;
  logic                        busy_r;
  logic                        start_r;
  logic                        valid_r;
  logic [NUM_OUT*FP_TOTAL-1:0] result_r;

  crop_window_filter u_filter (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .en        (stream_en_s),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .buf_empty (buf_empty_s),
    .frame_end (frame_end_s)
  );

  // Next-state and lane-capture decode.
  always_comb begin
    next_s      = state_r;
    stream_en_s = (state_r == STREAM);
    collect_s   = is_collect(state_r);
    release_s   = (state_r == RESULT) && result_ready;
    take_s      = collect_s ? (res_tvalid & ~got_r) : '0;
    if (release_s) begin
      got_next_s = '0;
    end else begin
      got_next_s = got_r | take_s;
    end
    case (state_r)
      IDLE:    next_s = cmd_start ? START : IDLE;
      START:   next_s = net_ap_ready ? STREAM : START;
      STREAM:  next_s = frame_end_s ? DRAIN : STREAM;
      DRAIN:   next_s = (buf_empty_s && done_seen_r && (&got_r)) ? RESULT : DRAIN;
      RESULT:  next_s = result_ready ? IDLE : RESULT;
      default: next_s = IDLE;
    endcase
  end

  // State register; control outputs are registered from the next state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
      valid_r     <= 1'b0;
      res_ready_r <= '0;
    end else begin
      state_r     <= next_s;
      busy_r      <= (next_s != IDLE);
      start_r     <= (next_s == START);
      valid_r     <= (next_s == RESULT);
      res_ready_r <= is_collect(next_s) ? ~got_next_s : '0;
    end
  end

  // Lane capture and done tracking; result_data keeps the last captures across frames.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      got_r       <= '0;
      done_seen_r <= 1'b0;
      result_r    <= '0;
    end else begin
      got_r <= got_next_s;
      if (release_s) begin
        done_seen_r <= 1'b0;
      end else if (collect_s && net_ap_done) begin
        done_seen_r <= 1'b1;
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (take_s[k]) begin
          result_r[k*FP_TOTAL +: FP_TOTAL] <= res_tdata[k*FP_TOTAL +: FP_TOTAL];
        end
      end
    end
  end

  assign busy         = busy_r;
  assign net_ap_start = start_r;
  assign result_valid = valid_r;
  assign res_tready   = res_ready_r;
  assign result_data  = result_r;

endmodule

// File: tb/tb_crop_frame_sequencer.sv
// Directed bench for crop_frame_sequencer with a frame-level model of the crop window.
module tb_crop_frame_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        busy;
  logic [15:0] s_tdata = 16'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        net_ap_start;
  logic        net_ap_ready = 1'b0;
  logic        net_ap_done = 1'b0;
  logic [79:0] res_tdata = 80'd0;
  logic [4:0]  res_tvalid = 5'd0;
  logic [4:0]  res_tready;
  logic [79:0] result_data;
  logic        result_valid;
  logic        result_ready = 1'b0;

  crop_frame_sequencer dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .cmd_start    (cmd_start),
    .busy         (busy),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .net_ap_start (net_ap_start),
    .net_ap_ready (net_ap_ready),
    .net_ap_done  (net_ap_done),
    .res_tdata    (res_tdata),
    .res_tvalid   (res_tvalid),
    .res_tready   (res_tready),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 ap_clk = ~ap_clk;

  int          errors = 0;
  int          checks = 0;
  int          pix = 0;
  int          stream_cycles = 0;
  int          m_idx = 0;
  int          frame_id = 0;
  bit          pix_done = 1'b0;
  logic [15:0] exp_pix [2304];
  logic [15:0] beats [2304];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] lanes(input logic [15:0] base);
    logic [79:0] w;
    for (int k = 0; k < 5; k++) w[k*16 +: 16] = base + 16'(k);
    return w;
  endfunction

  // Every-cycle check of the network-input stream against the expected crop sequence.
  task automatic compare_loop();
    int   seen_id = 0;
    bit   stall_prev = 1'b0;
    logic [15:0] stall_data = 16'd0;
    forever begin
      @(negedge ap_clk);
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        m_idx = 0;
      end
      if (ap_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("m_valid_hold", m_tvalid, 1'b1);
          chk("m_data_stable", m_tdata, stall_data);
        end
        if (m_tvalid && m_tready) begin
          if (m_idx < 2304) begin
            chk("m_beat", m_tdata, exp_pix[m_idx]);
            beats[m_idx] = m_tdata;
          end else begin
            chk("m_extra_beat", m_idx + 1, 2304);
          end
          m_idx++;
        end
        if (!busy) begin
          chk("s_tready_idle", s_tready, 1'b0);
          chk("res_tready_idle", res_tready, 5'd0);
        end
        stall_prev = m_tvalid && !m_tready;
        stall_data = m_tdata;
      end
    end
  endtask

  task automatic start_frame();
    frame_id++;
    @(posedge ap_clk); #1 cmd_start = 1'b1;
    @(negedge ap_clk); chk("start_before_edge", net_ap_start, 1'b0);
    @(posedge ap_clk); #1 cmd_start = 1'b0;
    @(negedge ap_clk); chk("start_rise", net_ap_start, 1'b1); chk("busy_start", busy, 1'b1);
    @(posedge ap_clk); #1 net_ap_ready = 1'b1;
    @(negedge ap_clk); chk("start_hold", net_ap_start, 1'b1);
    @(posedge ap_clk); #1 net_ap_ready = 1'b0;
    @(negedge ap_clk); chk("start_fall", net_ap_start, 1'b0);
  endtask

  task automatic drive_pixels(input bit rnd, input int stop_at);
    int guard = 0;
    bit acc;
    bit started = 1'b0;
    pix = 0;
    stream_cycles = 0;
    @(posedge ap_clk); #1;
    while (pix < stop_at && guard < 40000) begin
      s_tdata  = 16'(pix);
      s_tvalid = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      @(negedge ap_clk);
      acc = s_tvalid && s_tready;
      if (acc) started = 1'b1;
      if (started) stream_cycles++;
      @(posedge ap_clk); #1;
      if (acc) pix++;
      guard++;
    end
    s_tvalid = 1'b0;
    if (pix < stop_at) chk("pixel_timeout", pix, stop_at);
  endtask

  task automatic offer_lane(input int k, input logic [15:0] v);
    int g = 0;
    @(posedge ap_clk); #1;
    res_tdata[k*16 +: 16] = v;
    res_tvalid[k] = 1'b1;
    @(negedge ap_clk);
    while (!res_tready[k] && g < 50) begin
      @(negedge ap_clk);
      g++;
    end
    if (!res_tready[k]) chk("lane_timeout", res_tready[k], 1'b1);
    @(posedge ap_clk); #1 res_tvalid[k] = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge ap_clk); #1 net_ap_done = 1'b1;
    @(posedge ap_clk); #1 net_ap_done = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int g = 0;
    while (!result_valid && g < limit) begin
      @(negedge ap_clk);
      g++;
    end
    if (!result_valid) chk("result_timeout", result_valid, 1'b1);
  endtask

  task automatic check_frame(input bit full_rate);
    chk("m_count", m_idx, 2304);
    chk("m_first", beats[0], 16'd1610);
    chk("m_48th", beats[47], 16'd1657);
    chk("m_49th", beats[48], 16'd1770);
    chk("m_last", beats[2303], 16'd9177);
    if (full_rate) chk("stream_cycles", stream_cycles, 16000);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_s_tready"}, s_tready, 1'b0);
    chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_tdata, 16'd0);
    chk({tag, "_net_ap_start"}, net_ap_start, 1'b0);
    chk({tag, "_res_tready"}, res_tready, 5'd0);
    chk({tag, "_result_valid"}, result_valid, 1'b0);
    chk({tag, "_result_data"}, result_data, 80'd0);
  endtask

  initial begin
    int g;
    int cnt;
    for (int r = 0; r < 48; r++)
      for (int c = 0; c < 48; c++)
        exp_pix[r*48 + c] = 16'((r + 10) * 160 + (c + 10));
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_all_zero("reset");
    ap_rst = 1'b0;

    // Frame A: full-rate ramp, lanes out of order, duplicate lane 2, done mid-stream.
    start_frame();
    fork
      drive_pixels(1'b0, 16000);
      begin
        offer_lane(3, 16'hA003);
        offer_lane(0, 16'hA000);
        offer_lane(4, 16'hA004);
        offer_lane(1, 16'hA001);
        offer_lane(2, 16'hA002);
        @(posedge ap_clk); #1;
        res_tdata[32 +: 16] = 16'hBEEF;
        res_tvalid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge ap_clk);
          chk("lane2_stall", res_tready[2], 1'b0);
        end
        @(posedge ap_clk); #1 res_tvalid[2] = 1'b0;
        g = 0;
        while (pix < 8000 && g < 20000) begin
          @(posedge ap_clk);
          g++;
        end
        #1 net_ap_done = 1'b1;
        @(posedge ap_clk); #1 net_ap_done = 1'b0;
        @(negedge ap_clk);
        chk("valid_before_last", result_valid, 1'b0);
      end
    join
    @(negedge ap_clk);
    chk("valid_in_drain", result_valid, 1'b0);
    wait_valid(10);
    chk("result_a", result_data, lanes(16'hA000));
    check_frame(1'b1);

    // Hold the result unconsumed with an ignored start in the window.
    for (int i = 0; i < 100; i++) begin
      @(posedge ap_clk); #1 cmd_start = (i == 50);
      @(negedge ap_clk);
      if (i % 10 == 0 || (i >= 50 && i <= 53)) begin
        chk("hold_valid", result_valid, 1'b1);
        chk("hold_data", result_data, lanes(16'hA000));
        chk("hold_busy", busy, 1'b1);
        chk("hold_no_start", net_ap_start, 1'b0);
      end
    end
    cmd_start = 1'b0;
    @(posedge ap_clk); #1 result_ready = 1'b1; cmd_start = 1'b1;
    @(posedge ap_clk); #1 result_ready = 1'b0; cmd_start = 1'b0;
    @(negedge ap_clk);
    chk("release_busy", busy, 1'b0);
    chk("release_valid", result_valid, 1'b0);
    chk("release_data_kept", result_data, lanes(16'hA000));
    repeat (2) @(negedge ap_clk);
    chk("coincident_start_ignored", busy, 1'b0);
    chk("coincident_no_ap_start", net_ap_start, 1'b0);

    // Frame B: random source valid and sink ready.
    start_frame();
    pix_done = 1'b0;
    fork
      begin
        drive_pixels(1'b1, 16000);
        pix_done = 1'b1;
      end
      begin
        while (!pix_done) begin
          @(posedge ap_clk); #1 m_tready = ($urandom_range(0, 1) != 0);
        end
        m_tready = 1'b1;
      end
      begin
        for (int k = 0; k < 5; k++) offer_lane(k, 16'hB000 + 16'(k));
        pulse_done();
      end
    join
    @(negedge ap_clk);
    wait_valid(50);
    chk("result_b", result_data, lanes(16'hB000));
    check_frame(1'b0);
    @(posedge ap_clk); #1 result_ready = 1'b1;
    @(posedge ap_clk); #1 result_ready = 1'b0;
    @(negedge ap_clk);
    chk("idle_after_b", busy, 1'b0);

    // Frame C: reset between clock edges at pixel 5000.
    start_frame();
    fork
      drive_pixels(1'b0, 5000);
      begin
        for (int k = 0; k < 5; k++) offer_lane(k, 16'hC000 + 16'(k));
        pulse_done();
      end
    join
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_m_tvalid", m_tvalid, 1'b1);
    chk("pre_reset_result", result_data, lanes(16'hC000));
    #2 ap_rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;

    // Frame D: repeat of frame A; done, final lane and last pixel in one cycle.
    result_ready = 1'b1;
    start_frame();
    fork
      drive_pixels(1'b0, 16000);
      begin
        for (int k = 0; k < 4; k++) offer_lane(k, 16'hA000 + 16'(k));
        g = 0;
        @(negedge ap_clk);
        while (pix != 15999 && g < 30000) begin
          @(negedge ap_clk);
          g++;
        end
        if (pix == 15999) begin
          chk("last_lane_ready", res_tready[4], 1'b1);
          chk("valid_before_final", result_valid, 1'b0);
          res_tdata[64 +: 16] = 16'hA004;
          res_tvalid[4] = 1'b1;
          net_ap_done = 1'b1;
          @(posedge ap_clk); #1;
          res_tvalid[4] = 1'b0;
          net_ap_done = 1'b0;
        end else begin
          chk("final_pixel_timeout", pix, 15999);
        end
      end
    join
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (result_valid) begin
        cnt++;
        chk("result_d", result_data, lanes(16'hA000));
      end
    end
    chk("result_once", cnt, 1);
    result_ready = 1'b0;
    chk("idle_after_d", busy, 1'b0);
    check_frame(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
